// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared definitions for the data-memory arbiter: FSM state
//                encoding, requester identifiers and default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    // Arbiter states: free arbitration, or port owned by the aux master.
    typedef enum logic {
        ARB   = 1'b0,
        LOCKA = 1'b1
    } arb_state_t;

    // Requester identifiers, used for the round-robin "last granted" record.
    typedef enum logic {
        REQ_C = 1'b0,
        REQ_A = 1'b1
    } req_id_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares one single-port data memory (combinational read,
//                synchronous write) between the core load/store stage (C)
//                and an auxiliary master (A). Round-robin on contention,
//                optional aux burst locking bounded by MAX_LOCK beats.
//  Ports       : clk/reset          - clock, synchronous active-high reset
//                c_*                - core request/grant/stall/read return
//                a_*                - aux request/lock/grant/read return
//                mem_*              - memory port (mux of granted requester)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              reset,
    // core requester
    input  logic              c_req,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_gnt,
    output logic              c_stall,
    output logic              c_rvalid,
    output logic [DATA_W-1:0] c_rdata,
    // aux requester
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_lock,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    // memory
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int               CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_LOCK);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    req_id_t          r_last;
    req_id_t          w_last_nxt;
    logic [CNT_W-1:0] r_lock_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_c_gnt;
    logic             w_a_gnt;
    logic             w_force;

    logic              r_c_rvalid;
    logic [DATA_W-1:0] r_c_rdata;
    logic              r_a_rvalid;
    logic [DATA_W-1:0] r_a_rdata;

    // Lock has run its full length and the core is waiting: the core takes
    // the port in this very cycle so its wait stays within MAX_LOCK+1.
    assign w_force = (r_state == LOCKA) && (r_lock_cnt == C_MAX) && c_req;

    always_comb begin
        w_c_gnt     = 1'b0;
        w_a_gnt     = 1'b0;
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_lock_cnt;
        if (!reset) begin
            case (r_state)
                ARB: begin
                    if (c_req && a_req) begin
                        w_c_gnt = (r_last == REQ_A);
                        w_a_gnt = (r_last == REQ_C);
                    end else begin
                        w_c_gnt = c_req;
                        w_a_gnt = a_req;
                    end
                    if (w_a_gnt && a_lock) begin
                        w_state_nxt = LOCKA;
                        w_cnt_nxt   = C_ONE;
                    end
                end
                LOCKA: begin
                    if (w_force) begin
                        w_c_gnt     = 1'b1;
                        w_state_nxt = ARB;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_a_gnt = a_req;
                        if (!a_req || !a_lock) begin
                            // Leaving the lock hands priority to the core.
                            w_state_nxt = ARB;
                            w_cnt_nxt   = '0;
                            w_last_nxt  = REQ_A;
                        end else if (r_lock_cnt < C_MAX) begin
                            w_cnt_nxt = r_lock_cnt + C_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ARB;
                    w_cnt_nxt   = '0;
                end
            endcase
            if (w_c_gnt) begin
                w_last_nxt = REQ_C;
            end else if (w_a_gnt) begin
                w_last_nxt = REQ_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ARB;
            r_last     <= REQ_A;
            r_lock_cnt <= '0;
            r_c_rvalid <= 1'b0;
            r_c_rdata  <= '0;
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_lock_cnt <= w_cnt_nxt;
            r_c_rvalid <= w_c_gnt && !c_we;
            r_a_rvalid <= w_a_gnt && !a_we;
            if (w_c_gnt && !c_we) begin
                r_c_rdata <= mem_rdata;
            end
            if (w_a_gnt && !a_we) begin
                r_a_rdata <= mem_rdata;
            end
        end
    end

    assign c_gnt     = w_c_gnt;
    assign a_gnt     = w_a_gnt;
    assign c_stall   = c_req && !w_c_gnt;
    assign c_rvalid  = r_c_rvalid;
    assign c_rdata   = r_c_rdata;
    assign a_rvalid  = r_a_rvalid;
    assign a_rdata   = r_a_rdata;
    assign mem_we    = (w_c_gnt && c_we) || (w_a_gnt && a_we);
    assign mem_addr  = w_a_gnt ? a_addr  : c_addr;
    assign mem_wdata = w_a_gnt ? a_wdata : c_wdata;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a behavioural
//                memory, a reference arbitration model and directed plus
//                randomized stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int AW       = 32;
    localparam int DW       = 32;
    localparam int MAX_LOCK = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          c_req, c_we, a_req, a_we, a_lock;
    logic [AW-1:0] c_addr, a_addr;
    logic [DW-1:0] c_wdata, a_wdata;
    logic          c_gnt, c_stall, c_rvalid, a_gnt, a_rvalid, mem_we;
    logic [DW-1:0] c_rdata, a_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_LOCK(MAX_LOCK)) u_dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_lock(a_lock), .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Behavioural memory attached to the DUT: 16 words.
    bit [DW-1:0] dmem [16];
    assign mem_rdata = dmem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (mem_we) dmem[mem_addr[5:2]] <= mem_wdata;
    end

    // Reference model state
    bit          m_locked;
    int          m_beats;
    bit          m_last_aux;
    bit          e_c_rv, e_a_rv;
    logic [DW-1:0] e_c_rd, e_a_rd;
    bit [DW-1:0] refmem [16];

    int n_vec;
    int n_err;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance to the next drive point, just after a rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called with inputs settled: check outputs against the model, then
    // advance the model across the coming clock edge.
    task automatic evaluate();
        bit g_c, g_a, forced;
        #3;
        g_c = 0; g_a = 0; forced = 0;
        if (!reset) begin
            if (m_locked) begin
                if (m_beats == MAX_LOCK && c_req) begin
                    g_c = 1; forced = 1;
                end else begin
                    g_a = a_req;
                end
            end else if (c_req && a_req) begin
                g_c = m_last_aux;
                g_a = !m_last_aux;
            end else begin
                g_c = c_req;
                g_a = a_req;
            end
        end
        check_val("c_gnt", c_gnt, g_c);
        check_val("a_gnt", a_gnt, g_a);
        check_val("c_stall", c_stall, c_req && !g_c);
        check_val("mem_we", mem_we, (g_c && c_we) || (g_a && a_we));
        if (g_c) check_val("mem_addr_c", mem_addr, c_addr);
        if (g_a) check_val("mem_addr_a", mem_addr, a_addr);
        if (g_c && c_we) check_val("mem_wdata_c", mem_wdata, c_wdata);
        if (g_a && a_we) check_val("mem_wdata_a", mem_wdata, a_wdata);
        check_val("c_rvalid", c_rvalid, e_c_rv);
        check_val("a_rvalid", a_rvalid, e_a_rv);
        check_val("c_rdata", c_rdata, e_c_rd);
        check_val("a_rdata", a_rdata, e_a_rd);

        // Model update for the edge that ends this cycle.
        if (reset) begin
            m_locked = 0; m_beats = 0; m_last_aux = 1;
            e_c_rv = 0; e_a_rv = 0; e_c_rd = '0; e_a_rd = '0;
        end else begin
            e_c_rv = g_c && !c_we;
            e_a_rv = g_a && !a_we;
            if (e_c_rv) e_c_rd = refmem[c_addr[5:2]];
            if (e_a_rv) e_a_rd = refmem[a_addr[5:2]];
            if (g_c && c_we) refmem[c_addr[5:2]] = c_wdata;
            if (g_a && a_we) refmem[a_addr[5:2]] = a_wdata;
            if (!m_locked) begin
                if (g_a && a_lock) begin
                    m_locked = 1; m_beats = 1;
                end
            end else if (forced || !a_req || !a_lock) begin
                m_locked = 0; m_beats = 0; m_last_aux = 1;
            end else if (m_beats < MAX_LOCK) begin
                m_beats++;
            end
            if (g_c) m_last_aux = 0;
            else if (g_a) m_last_aux = 1;
        end
    endtask

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0; a_lock = 0;
    endtask

    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            next_cycle();
            reset = 1; idle_inputs();
            evaluate();
        end
        next_cycle();
        reset = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_locked = 0; m_beats = 0; m_last_aux = 1;
        e_c_rv = 0; e_a_rv = 0; e_c_rd = '0; e_a_rd = '0;
        reset = 1;
        idle_inputs();

        do_reset(2);
        check_val("rst_c_rvalid", c_rvalid, 1'b0);
        check_val("rst_a_rdata", a_rdata, '0);

        // Aux preloads 0xDEADBEEF at 0x10, then a core-only load.
        a_req = 1; a_we = 1; a_addr = 32'h10; a_wdata = 32'hDEADBEEF;
        evaluate();
        next_cycle(); idle_inputs();
        c_req = 1; c_we = 0; c_addr = 32'h10;
        evaluate();
        check_val("cload_gnt", c_gnt, 1'b1);
        check_val("cload_stall", c_stall, 1'b0);
        next_cycle(); idle_inputs();
        evaluate();
        check_val("cload_rvalid", c_rvalid, 1'b1);
        check_val("cload_rdata", c_rdata, 32'hDEADBEEF);
        check_val("cload_a_rvalid", a_rvalid, 1'b0);

        // Contention right after reset: core first, then aux.
        next_cycle();
        do_reset(1);
        c_req = 1; c_we = 1; c_addr = 32'h20; c_wdata = 32'h1111_2222;
        a_req = 1; a_we = 1; a_addr = 32'h24; a_wdata = 32'h3333_4444;
        evaluate();
        check_val("cont0_c_gnt", c_gnt, 1'b1);
        check_val("cont0_addr", mem_addr, 32'h20);
        check_val("cont0_stall", c_stall, 1'b0);
        next_cycle(); c_req = 0;
        evaluate();
        check_val("cont1_a_gnt", a_gnt, 1'b1);
        check_val("cont1_addr", mem_addr, 32'h24);

        // Round-robin: both loading for 6 cycles.
        for (int i = 0; i < 6; i++) begin
            next_cycle();
            c_req = 1; c_we = 0; c_addr = 32'(4 * i);
            a_req = 1; a_we = 0; a_addr = 32'(4 * i + 32);
            evaluate();
            check_val("rr_c_gnt", c_gnt, (i % 2) == 0);
        end
        next_cycle(); idle_inputs(); evaluate();

        // Lock bound: aux locked burst, core requesting from cycle 1.
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            a_req = 1; a_lock = 1; a_we = 0; a_addr = 32'(4 * i);
            c_req = (i >= 1 && i <= 4); c_we = 0; c_addr = 32'h3C;
            evaluate();
            if (i <= 4) begin
                check_val("lock_a_gnt", a_gnt, i < 4);
                check_val("lock_c_gnt", c_gnt, i == 4);
                check_val("lock_stall", c_stall, i >= 1 && i <= 3);
            end
        end
        next_cycle(); idle_inputs(); evaluate();

        // Lock with idle core: never released.
        for (int i = 0; i < 8; i++) begin
            next_cycle();
            a_req = 1; a_lock = 1; a_we = 1; a_addr = 32'(4 * i); a_wdata = 32'(i + 100);
            evaluate();
            check_val("lockidle_a_gnt", a_gnt, 1'b1);
        end

        // Aux load inside the lock, then reset in the next cycle.
        next_cycle();
        a_we = 0; a_addr = 32'h08;
        evaluate();
        next_cycle();
        reset = 1; idle_inputs(); a_req = 1; a_lock = 1; a_we = 1;
        evaluate();
        check_val("rstlock_mem_we", mem_we, 1'b0);
        next_cycle(); reset = 0; idle_inputs();
        c_req = 1; c_we = 0; c_addr = 32'h08;
        a_req = 1; a_we = 0; a_addr = 32'h0C;
        evaluate();
        check_val("rstlock_a_rvalid", a_rvalid, 1'b0);
        check_val("rstlock_core_wins", c_gnt, 1'b1);

        // Randomized traffic; requests tend to be held until granted.
        for (int i = 0; i < 400; i++) begin
            logic keep_c, keep_a;
            keep_c = c_req && !c_gnt && ($urandom_range(0, 9) < 8);
            keep_a = a_req && !a_gnt && ($urandom_range(0, 9) < 8);
            next_cycle();
            reset = ($urandom_range(0, 99) == 0);
            if (!keep_c) begin
                c_req = $urandom_range(0, 1); c_we = $urandom_range(0, 1);
                c_addr = {26'($urandom), 4'($urandom), 2'b00}; c_wdata = $urandom;
            end
            if (!keep_a) begin
                a_req = $urandom_range(0, 1); a_we = $urandom_range(0, 1);
                a_addr = {26'($urandom), 4'($urandom), 2'b00}; a_wdata = $urandom;
            end
            a_lock = ($urandom_range(0, 3) != 0);
            evaluate();
        end

        next_cycle(); reset = 0; idle_inputs(); evaluate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipelined core's load/store stage (requester C) and an auxiliary master (requester A: program loader/debug port).
- Sits between core/aux and the data memory, which has combinational read and synchronous write.
- Round-robin arbitration on contention. Optional aux bus locking for bursts, bounded by a lock-length counter so the core cannot starve.
- Drives a core stall request while a core access is pending and not granted.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_LOCK, 4, maximum consecutive locked aux beats before a forced release (must be ≥1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- c_req  in  1  core access request, held until granted
- c_we  in  1  core write enable (0 = load)
- c_addr  in  ADDR_W  core byte address
- c_wdata  in  DATA_W  core store data
- c_gnt  out  1  core granted this cycle (combinational)
- c_stall  out  1  c_req & ~c_gnt, to pipeline hazard logic
- c_rvalid  out  1  core load data valid (registered)
- c_rdata  out  DATA_W  core load data (registered)
- a_req, a_we, a_addr, a_wdata  in  1/1/ADDR_W/DATA_W  aux request, same rules as core
- a_lock  in  1  aux asks to keep ownership after the current beat
- a_gnt  out  1  aux granted this cycle
- a_rvalid  out  1  aux load data valid
- a_rdata  out  DATA_W  aux load data
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory combinational read data

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high. While reset is high, c_gnt, a_gnt and mem_we are 0.
- Reset values: c_rvalid=a_rvalid=0, c_rdata=a_rdata=0, state=ARB, last=A (core wins the first contention), lock_cnt=0.
- Grant is combinational, at most one per cycle:
  - c_gnt & a_gnt is never 1.
  - A granted beat completes in that cycle: a write commits at the clock edge, and read data is captured at the edge.
- Mux: mem_addr, mem_wdata and mem_we (= we & gnt) come from the granted requester. With no grant, mem_we=0 and mem_addr/wdata hold the core values (don't-care).
- Read return: when a granted beat has we=0, the requester's rvalid=1 on the next cycle with rdata = mem_rdata sampled at the grant edge. rvalid is a single-cycle pulse. rdata holds its value until the next load.
- Writes never produce rvalid.
- State ARB:
  - Only one requester active → grant it.
  - Both active → grant the requester ≠ last.
  - last updates to the granted ID on every grant.
  - Aux granted with a_lock=1 → go to LOCKA, lock_cnt=1.
- State LOCKA:
  - Aux owns the port. a_gnt = a_req. The core is not granted.
  - Each cycle with a_gnt & a_lock and lock_cnt<MAX_LOCK: lock_cnt++, stay.
  - Exit to ARB when any of these holds: a_lock=0, a_req=0, or lock_cnt==MAX_LOCK with c_req=1 (forced release).
  - On exit, last=A, so the core wins the next contention.
  - lock_cnt==MAX_LOCK with c_req=0: stay locked and hold lock_cnt saturated.
- Starvation bound: a held c_req is granted within MAX_LOCK+1 cycles.
- Simultaneous events:
  - A grant and the previous beat's rvalid may coincide (back-to-back loads at full throughput, 1 beat/cycle).
  - A request deasserted without a grant is legal and leaves no side effects.
- Reset mid-operation: pending rvalids are cleared, lock is dropped, and no memory write occurs in the reset cycle.
- Widths: addresses and data pass through unmodified. No alignment checking or byte lanes; sub-word handling stays in the core.

Decomposition:
- Shared package `mem_arb_pkg`:
  - state encoding localparams (ARB=1'b0, LOCKA=1'b1)
  - requester IDs (REQ_C=1'b0, REQ_A=1'b1)
  - default ADDR_W/DATA_W
- No sub-module. The arbiter FSM, lock counter, mux and read-return registers stay in one module of about 150–200 lines.

Test Plan:
- Core-only load: c_req=1, c_we=0, c_addr=0x10, mem holds 0xDEADBEEF → c_gnt=1 and c_stall=0 the same cycle; next cycle c_rvalid=1, c_rdata=0xDEADBEEF; a_rvalid stays 0.
- Contention after reset: c_req=a_req=1 (both writes, to 0x20 and 0x24) → cycle 0 grants C (mem_we=1, mem_addr=0x20); cycle 1 grants A (mem_addr=0x24); c_stall=0 in cycle 0.
- Round-robin: both requesting continuously for 6 cycles → grants alternate C,A,C,A,C,A; each requester's rvalid follows its own load one cycle later.
- Lock bound: MAX_LOCK=4, a_req=a_lock=1 for 10 cycles, c_req=1 from cycle 1 → aux granted cycles 0–3, core granted cycle 4, c_stall=1 in cycles 1–3.
- Lock with idle core: a_lock=1 for 8 beats, c_req=0 → aux granted all 8 cycles; lock_cnt saturates at 4; no release.
- Reset mid-lock: LOCKA with an aux load issued in cycle N; reset=1 in cycle N+1 → a_rvalid=0, mem_we=0, state=ARB; after reset, core wins contention.
